// File: rtl/control_unit.sv
// Multi-cycle control sequencer: fetch T0-T2, opcode-dependent execute T3-T7, sticky HALT on an illegal opcode.
// Controls are decoded from state and ir_opcode in the same cycle; done and illegal are registered.
module control_unit (
    input  logic       clk,
    input  logic       clr,
    input  logic       run,
    input  logic [4:0] ir_opcode,
    output logic       pc_out,
    output logic       zlo_out,
    output logic       zhi_out,
    output logic       mdr_out,
    output logic       r_out,
    output logic       ba_out,
    output logic       c_sign_extended_out,
    output logic       mar_enable,
    output logic       mdr_enable,
    output logic       ir_enable,
    output logic       y_enable,
    output logic       z_enable,
    output logic       pc_enable,
    output logic       lo_enable,
    output logic       hi_enable,
    output logic       r_in,
    output logic       gra,
    output logic       grb,
    output logic       grc,
    output logic       read,
    output logic       ram_write,
    output logic       pc_increment,
    output logic [4:0] alu_op,
    output logic       done,
    output logic       illegal
);
    typedef enum logic [3:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6, T7, HALT
    } state_t;

    state_t state;

    logic is_ld, is_ldi, is_st, is_r, is_imm, is_md, is_un, is_legal;

    always_comb begin
        is_ld    = (ir_opcode == 5'b00000);
        is_ldi   = (ir_opcode == 5'b00001);
        is_st    = (ir_opcode == 5'b00010);
        is_r     = (ir_opcode >= 5'b00011) && (ir_opcode <= 5'b01011);
        is_imm   = (ir_opcode >= 5'b01100) && (ir_opcode <= 5'b01110);
        is_md    = (ir_opcode == 5'b01111) || (ir_opcode == 5'b10000);
        is_un    = (ir_opcode == 5'b10001) || (ir_opcode == 5'b10010);
        is_legal = (ir_opcode <= 5'b10010);
    end

    // Leaving the final execute state either chains straight into the next fetch or parks in IDLE.
    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= IDLE;
            done    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (run) state <= T0;
                T0:   state <= T1;
                T1:   state <= T2;
                T2:   state <= T3;
                T3: begin
                    if (!is_legal) begin
                        state   <= HALT;
                        illegal <= 1'b1;
                    end else begin
                        state <= T4;
                    end
                end
                T4: begin
                    if (is_un) begin
                        state <= run ? T0 : IDLE;
                        done  <= !run;
                    end else begin
                        state <= T5;
                    end
                end
                T5: begin
                    if (is_r || is_imm || is_ldi) begin
                        state <= run ? T0 : IDLE;
                        done  <= !run;
                    end else begin
                        state <= T6;
                    end
                end
                T6: begin
                    if (is_md) begin
                        state <= run ? T0 : IDLE;
                        done  <= !run;
                    end else begin
                        state <= T7;
                    end
                end
                T7: begin
                    state <= run ? T0 : IDLE;
                    done  <= !run;
                end
                HALT:    state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        pc_out = 1'b0; zlo_out = 1'b0; zhi_out = 1'b0; mdr_out = 1'b0;
        r_out = 1'b0; ba_out = 1'b0; c_sign_extended_out = 1'b0;
        mar_enable = 1'b0; mdr_enable = 1'b0; ir_enable = 1'b0; y_enable = 1'b0;
        z_enable = 1'b0; pc_enable = 1'b0; lo_enable = 1'b0; hi_enable = 1'b0;
        r_in = 1'b0; gra = 1'b0; grb = 1'b0; grc = 1'b0;
        read = 1'b0; ram_write = 1'b0; pc_increment = 1'b0;
        alu_op = 5'b00000;
        case (state)
            T0: begin pc_out = 1'b1; mar_enable = 1'b1; pc_increment = 1'b1; z_enable = 1'b1; end
            T1: begin zlo_out = 1'b1; pc_enable = 1'b1; read = 1'b1; mdr_enable = 1'b1; end
            T2: begin mdr_out = 1'b1; ir_enable = 1'b1; end
            T3: begin
                if (is_r || is_imm) begin
                    grb = 1'b1; r_out = 1'b1; y_enable = 1'b1;
                end else if (is_ld || is_ldi || is_st) begin
                    grb = 1'b1; ba_out = 1'b1; y_enable = 1'b1;
                end else if (is_md) begin
                    gra = 1'b1; r_out = 1'b1; y_enable = 1'b1;
                end else if (is_un) begin
                    grb = 1'b1; r_out = 1'b1; z_enable = 1'b1; alu_op = ir_opcode;
                end
            end
            T4: begin
                if (is_r) begin
                    grc = 1'b1; r_out = 1'b1; z_enable = 1'b1; alu_op = ir_opcode;
                end else if (is_imm) begin
                    c_sign_extended_out = 1'b1; z_enable = 1'b1; alu_op = ir_opcode;
                end else if (is_ld || is_ldi || is_st) begin
                    c_sign_extended_out = 1'b1; z_enable = 1'b1; alu_op = 5'b00011;
                end else if (is_md) begin
                    grb = 1'b1; r_out = 1'b1; z_enable = 1'b1; alu_op = ir_opcode;
                end else if (is_un) begin
                    zlo_out = 1'b1; gra = 1'b1; r_in = 1'b1;
                end
            end
            T5: begin
                if (is_r || is_imm || is_ldi) begin
                    zlo_out = 1'b1; gra = 1'b1; r_in = 1'b1;
                end else if (is_ld || is_st) begin
                    zlo_out = 1'b1; mar_enable = 1'b1;
                end else if (is_md) begin
                    zlo_out = 1'b1; lo_enable = 1'b1;
                end
            end
            T6: begin
                if (is_ld) begin
                    read = 1'b1; mdr_enable = 1'b1;
                end else if (is_st) begin
                    gra = 1'b1; r_out = 1'b1; mdr_enable = 1'b1;
                end else if (is_md) begin
                    zhi_out = 1'b1; hi_enable = 1'b1;
                end
            end
            T7: begin
                if (is_ld) begin
                    mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1;
                end else if (is_st) begin
                    ram_write = 1'b1;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 clk  in  1  system clock; all state changes on rising edge.
REQ-002 clr  in  1  synchronous, active-high reset.
REQ-003 run  in  1  level; 1 = keep issuing instructions, 0 = stop at next instruction boundary.
REQ-004 ir_opcode  in  5  IR[31:27], valid from the cycle after T2.
REQ-005 pc_out, zlo_out, zhi_out, mdr_out, r_out, ba_out, c_sign_extended_out  out  1 each  bus-drive selects.
REQ-006 mar_enable, mdr_enable, ir_enable, y_enable, z_enable, pc_enable, lo_enable, hi_enable, r_in  out  1 each  register load enables.
REQ-007 gra, grb, grc  out  1 each  register-field select, at most one high per cycle.
REQ-008 read, ram_write, pc_increment  out  1 each  memory read, memory write, ALU PC+1 mode.
REQ-009 alu_op  out  5  ALU operation code.
REQ-010 done  out  1  one-cycle pulse on entering IDLE after an instruction.
REQ-011 illegal  out  1  sticky; unsupported opcode decoded.

Function
REQ-012 Every control output SHALL be a decoded function of state (and ir_opcode); each state lasts exactly one clk; all outputs not listed for a state are 0.
REQ-013 States: IDLE, T0..T7, HALT; IDLE->T0 when run=1.
REQ-014 Fetch: T0 pc_out, mar_enable, pc_increment, z_enable; T1 zlo_out, pc_enable, read, mdr_enable; T2 mdr_out, ir_enable.
REQ-015 Opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, shr 00101, shra 00110, shl 00111, ror 01000, rol 01001, and 01010, or 01011, addi 01100, andi 01101, ori 01110, mul 01111, div 10000, neg 10001, not 10010; all others illegal.
REQ-016 alu_op SHALL be 00011 (add) in the address/ldi compute cycle, ir_opcode in R/I/mul/div/unary compute cycles, 00000 otherwise.
REQ-017 R-format (add..or): T3 grb, r_out, y_enable; T4 grc, r_out, z_enable; T5 zlo_out, gra, r_in.
REQ-018 Immediate (addi, andi, ori): T3 grb, r_out, y_enable; T4 c_sign_extended_out, z_enable; T5 zlo_out, gra, r_in.
REQ-019 ldi: T3 grb, ba_out, y_enable; T4 c_sign_extended_out, z_enable; T5 zlo_out, gra, r_in.
REQ-020 ld: T3-T4 as ldi; T5 zlo_out, mar_enable; T6 read, mdr_enable; T7 mdr_out, gra, r_in.
REQ-021 st: T3-T4 as ldi; T5 zlo_out, mar_enable; T6 gra, r_out, mdr_enable; T7 ram_write.
REQ-022 mul/div: T3 gra, r_out, y_enable; T4 grb, r_out, z_enable; T5 zlo_out, lo_enable; T6 zhi_out, hi_enable.
REQ-023 neg/not: T3 grb, r_out, z_enable; T4 zlo_out, gra, r_in.
REQ-024 After the last execute state: next state T0 if run=1, else IDLE with done=1 for that one cycle.
REQ-025 Illegal opcode at T3: no execute controls; enter HALT, illegal=1; HALT persists regardless of run until clr.
REQ-026 run deassertion mid-instruction SHALL NOT truncate the instruction.
REQ-027 gra/grb/grc SHALL never overlap; r_in and r_out SHALL never be high together.

Reset
REQ-028 clr=1 at a rising edge: state=IDLE, illegal=0, done=0, all outputs 0 in the following cycle; clr overrides run and any mid-instruction state, including HALT.
REQ-029 No asynchronous behaviour; outputs before the first clr edge are don't-care.

Verification
REQ-030 clr, run=1, ir_opcode=01101 (andi) -> T0..T5 controls exactly per REQ-014/018; T4 alu_op=01101; then T0 again.
REQ-031 run=1 then 0 during T3 of ld (00000) -> T5 mar_enable, T6 read, T7 gra+r_in; next cycle IDLE with done=1 for 1 cycle.
REQ-032 st (00010) -> T6 gra+r_out+mdr_enable; T7 ram_write=1, r_in=0 throughout.
REQ-033 mul (01111) -> T5 lo_enable+zlo_out, T6 hi_enable+zhi_out, alu_op=01111 at T4.
REQ-034 ir_opcode=11111 -> HALT, illegal=1, held for 10 cycles with run=1; clr -> IDLE, illegal=0.
REQ-035 clr asserted during T4 of add -> next cycle IDLE, all outputs 0, no r_in pulse.
